// File: rtl/main_memory_responder_pkg.sv
// mem_resp_pkg: shared types and width helpers for the main memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_e;
  typedef enum logic {PORT_I, PORT_D} mem_port_e;
  function automatic int off_bits(input int bw_block);
    return $clog2(bw_block / 8);
  endfunction
  function automatic int idx_bits(input int num_block);
    return $clog2(num_block);
  endfunction
endpackage

// File: rtl/main_memory_responder_if.sv
// main_memory_responder_if: valid/ready block request channel from a cache toward main memory
interface main_memory_responder_if #(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128
);
  logic                  valid;
  logic                  r0w1;
  logic [BW_ADDRESS-1:0] rwaddr;
  logic [BW_BLOCK-1:0]   wdata;
  logic                  ready;
  logic [BW_BLOCK-1:0]   rdata;
  modport master (output valid, r0w1, rwaddr, wdata, input ready, rdata);
  modport slave  (input valid, r0w1, rwaddr, wdata, output ready, rdata);
endinterface

// File: rtl/main_memory_responder_rr_arbiter2.sv
// rr_arbiter2: two-request round-robin arbiter, ties go to the side not granted last
module rr_arbiter2 import mem_resp_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);
  mem_port_e last_grant;
  // remember which side won the most recent accepted request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= PORT_D;
    else if (update) last_grant <= grant[1] ? PORT_D : PORT_I;
  // a lone request is already one-hot; a tie flips away from the last winner
  always_comb grant = &req ? (last_grant == PORT_D ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency block memory serving I and D requesters one at a time
module main_memory_responder import mem_resp_pkg::*; #(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128,
  parameter int NUM_BLOCK  = 4096,
  parameter int LATENCY    = 8
) (
  input logic clk,
  input logic rst_n,
  main_memory_responder_if.slave I_mem,
  main_memory_responder_if.slave D_mem
);
  localparam int OW = off_bits(BW_BLOCK);
  localparam int IW = idx_bits(NUM_BLOCK);
  localparam int CW = $clog2(LATENCY + 1);
  mem_state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] grant;
  logic any_req;
  mem_port_e lat_port, sel_port, cur_port;
  logic lat_w, sel_w, cur_w;
  logic [IW-1:0] lat_idx, sel_idx, cur_idx;
  logic [BW_BLOCK-1:0] lat_wdata, sel_wdata, cur_wdata, resp_data;
  logic [BW_BLOCK-1:0] mem [NUM_BLOCK];
  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({D_mem.valid, I_mem.valid}),
    .update (state == IDLE && any_req),
    .grant  (grant)
  );
  // pick the granted request; in IDLE it comes straight from the ports, otherwise from the latch
  always_comb begin
    any_req   = I_mem.valid | D_mem.valid;
    sel_port  = grant[1] ? PORT_D : PORT_I;
    sel_w     = grant[1] ? D_mem.r0w1 : I_mem.r0w1;
    sel_idx   = grant[1] ? D_mem.rwaddr[OW +: IW] : I_mem.rwaddr[OW +: IW];
    sel_wdata = grant[1] ? D_mem.wdata : I_mem.wdata;
    cur_port  = state == IDLE ? sel_port : lat_port;
    cur_w     = state == IDLE ? sel_w : lat_w;
    cur_idx   = state == IDLE ? sel_idx : lat_idx;
    cur_wdata = state == IDLE ? sel_wdata : lat_wdata;
    resp_data = cur_w ? cur_wdata : mem[cur_idx];
    nxt = state == IDLE ? (any_req ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
        : state == BUSY ? (cnt == '0 ? RESP : BUSY)
        : IDLE;
  end
  // sequencing, request latch and registered response data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_port    <= PORT_I;
      lat_w       <= 1'b0;
      lat_idx     <= '0;
      lat_wdata   <= '0;
      I_mem.rdata <= '0;
      D_mem.rdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any_req) begin
        lat_port  <= sel_port;
        lat_w     <= sel_w;
        lat_idx   <= sel_idx;
        lat_wdata <= sel_wdata;
        cnt       <= CW'(LATENCY - 2);
      end else if (state == BUSY && cnt != '0) cnt <= cnt - CW'(1);
      if (nxt == RESP && cur_port == PORT_I) I_mem.rdata <= resp_data;
      if (nxt == RESP && cur_port == PORT_D) D_mem.rdata <= resp_data;
    end
  // array commits a write as RESP ends; a reset during the request leaves it untouched
  always_ff @(posedge clk)
    if (state == RESP && lat_w) mem[lat_idx] <= lat_wdata;
  assign I_mem.ready = state == RESP && lat_port == PORT_I;
  assign D_mem.ready = state == RESP && lat_port == PORT_D;
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed plus random request sequences checked against a cycle-level reference model
module tb_main_memory_responder;
  localparam int L  = 8;
  localparam int NB = 16;
  localparam int BB = 128;
  localparam int BA = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  main_memory_responder_if #(.BW_ADDRESS(BA), .BW_BLOCK(BB)) I_mem ();
  main_memory_responder_if #(.BW_ADDRESS(BA), .BW_BLOCK(BB)) D_mem ();
  main_memory_responder #(.BW_ADDRESS(BA), .BW_BLOCK(BB), .NUM_BLOCK(NB), .LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I_mem (I_mem),
    .D_mem (D_mem)
  );
  logic [BB-1:0] model [NB];
  logic [BB-1:0] exp_i = '0;
  logic [BB-1:0] exp_d = '0;
  bit last_d = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  function automatic int blk(input logic [BA-1:0] a);
    return int'((a >> 4) & BA'(NB - 1));
  endfunction
  function automatic logic [BB-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk1(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chkb(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_cycle(input logic ei, input logic ed);
    chk1("i_ready", I_mem.ready, ei);
    chk1("d_ready", D_mem.ready, ed);
    chkb("i_rdata", I_mem.rdata, exp_i);
    chkb("d_rdata", D_mem.rdata, exp_d);
  endtask
  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_cycle(1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask
  // present requests in cycle 0 and follow both sides until the last expected ready
  task automatic run(input bit iv, input bit iw, input logic [BA-1:0] ia, input logic [BB-1:0] idat,
                     input bit dv, input bit dw, input logic [BA-1:0] da, input logic [BB-1:0] ddat);
    int ti, td, last;
    ti = -1;
    td = -1;
    if (iv && dv) begin
      ti = last_d ? L : 2 * L + 1;
      td = last_d ? 2 * L + 1 : L;
      last_d = last_d;
    end else if (iv) begin
      ti = L;
      last_d = 1'b0;
    end else if (dv) begin
      td = L;
      last_d = 1'b1;
    end
    last = ti > td ? ti : td;
    I_mem.valid = iv; I_mem.r0w1 = iw; I_mem.rwaddr = ia; I_mem.wdata = idat;
    D_mem.valid = dv; D_mem.r0w1 = dw; D_mem.rwaddr = da; D_mem.wdata = ddat;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == ti) begin
        if (iw) begin exp_i = idat; model[blk(ia)] = idat; end
        else exp_i = model[blk(ia)];
      end
      if (c == td) begin
        if (dw) begin exp_d = ddat; model[blk(da)] = ddat; end
        else exp_d = model[blk(da)];
      end
      check_cycle(c == ti, c == td);
      @(posedge clk);
      #1;
      if (c == ti) I_mem.valid = 1'b0;
      if (c == td) D_mem.valid = 1'b0;
    end
  endtask
  initial begin
    logic [BA-1:0] a;
    bit iv, dv;
    I_mem.valid = 0; I_mem.r0w1 = 0; I_mem.rwaddr = '0; I_mem.wdata = '0;
    D_mem.valid = 0; D_mem.r0w1 = 0; D_mem.rwaddr = '0; D_mem.wdata = '0;
    @(negedge clk);
    check_cycle(1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(1, 1, 32'h0000_0040, rnd_blk(), 1, 1, 32'h0000_0050, rnd_blk());
    for (int k = 0; k < NB; k++) begin
      a = $urandom;
      a[7:4] = 4'(k);
      run(0, 0, '0, '0, 1, 1, a, rnd_blk());
    end
    run(0, 0, '0, '0, 1, 1, 32'h0000_0100, {16{8'hA5}});
    idle(2);
    run(1, 0, 32'h0000_0100, '0, 0, 0, '0, '0);
    run(0, 0, '0, '0, 1, 1, 32'h0000_0200, 128'h1234);
    run(0, 0, '0, '0, 1, 0, 32'h0000_020C, '0);
    idle(1);
    run(1, 0, 32'h0000_0070, '0, 0, 0, '0, '0);
    run(1, 0, 32'h0000_0080, '0, 1, 0, 32'h0000_0090, '0);
    run(0, 0, '0, '0, 1, 0, 32'h0000_00A0, '0);
    run(0, 0, '0, '0, 1, 0, 32'h0000_00B0, '0);
    run(0, 0, '0, '0, 1, 0, 32'h0000_00C0, '0);
    run(1, 1, 32'h0000_0000, rnd_blk(), 0, 0, '0, '0);
    run(1, 0, 32'h0000_0100, '0, 0, 0, '0, '0);
    idle(1);
    D_mem.valid = 1; D_mem.r0w1 = 1; D_mem.rwaddr = 32'h0000_0030; D_mem.wdata = rnd_blk();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_i = '0;
    exp_d = '0;
    last_d = 1'b1;
    check_cycle(1'b0, 1'b0);
    D_mem.valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    run(0, 0, '0, '0, 1, 0, 32'h0000_0030, '0);
    for (int n = 0; n < 60; n++) begin
      iv = 1'($urandom_range(0, 1));
      dv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
      idle($urandom_range(0, 2));
      run(iv, 1'($urandom_range(0, 1)), $urandom, rnd_blk(),
          dv, 1'($urandom_range(0, 1)), $urandom, rnd_blk());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
